// File: rtl/multicore_debug_pkg.sv
// Shared definitions for the Nios II debug virtual-JTAG host shifter.
// Holds the default register widths, the host FSM state type, the
// virtual IR encodings understood by the debug slave, and a helper that
// maps a state to its one-hot TAP strobe vector.
package multicore_debug_pkg;

  localparam int DBG_SR_WIDTH = 38;
  localparam int DBG_IR_WIDTH = 2;

  // Virtual IR encodings shared with the debug slave
  localparam logic [1:0] IR_OCIMEM    = 2'b00;
  localparam logic [1:0] IR_TRACE     = 2'b01;
  localparam logic [1:0] IR_BREAK     = 2'b10;
  localparam logic [1:0] IR_TRACECTRL = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    UIR,
    CDR,
    SDR,
    UDR,
    RTI,
    RESP
  } dbg_state_t;

  // Strobe vector bit order is {uir, cdr, sdr, udr, rti}; IDLE and RESP
  // drive no strobe at all.
  function automatic logic [4:0] state_strobes(input dbg_state_t s);
    case (s)
      UIR:     return 5'b10000;
      CDR:     return 5'b01000;
      SDR:     return 5'b00100;
      UDR:     return 5'b00010;
      RTI:     return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/multicore_cpu_1_cpu_debug_host_shifter_if.sv
// Command/response bus of the debug host shifter.
//   cmd_valid/cmd_ready/cmd_ir/cmd_data : one command (IR + data word) in
//   rsp_valid/rsp_ready/rsp_data/rsp_ir_out : captured word and IR status out
// The master modport is the side issuing commands; the slave modport is
// the shifter itself.
interface multicore_cpu_1_cpu_debug_host_shifter_if #(
  parameter int SR_WIDTH = multicore_debug_pkg::DBG_SR_WIDTH,
  parameter int IR_WIDTH = multicore_debug_pkg::DBG_IR_WIDTH
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [SR_WIDTH-1:0] cmd_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [SR_WIDTH-1:0] rsp_data;
  logic [IR_WIDTH-1:0] rsp_ir_out;

  modport master (
    output cmd_valid, cmd_ir, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ir_out
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_ir_out
  );

endinterface

// File: rtl/multicore_cpu_1_cpu_debug_host_tckgen.sv
// tck generator for the debug host shifter.
// While run is high, each tck period is TCK_DIV clk cycles low followed by
// TCK_DIV clk cycles high, with the first low cycle starting right after
// run rises. While run is low the phase counter sits at zero and tck is low.
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   run          : FSM is in a tck-driven state
//   tck          : registered tck
//   tck_rise_en  : the next clk edge raises tck
//   tck_fall_en  : the next clk edge ends the current period (tck falls)
module multicore_cpu_1_cpu_debug_host_tckgen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tck,
  output logic tck_rise_en,
  output logic tck_fall_en
);

  localparam int PH_W = $clog2(2 * TCK_DIV);
  localparam logic [PH_W-1:0] RISE_PH = PH_W'(TCK_DIV - 1);
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(2 * TCK_DIV - 1);

  logic [PH_W-1:0] phase;

  assign tck_rise_en = run && (phase == RISE_PH);
  assign tck_fall_en = run && (phase == LAST_PH);

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      phase <= '0;
    end else if (tck_fall_en) begin
      phase <= '0;
    end else begin
      phase <= phase + PH_W'(1);
    end
  end

  // tck is registered from the same pulses the FSM uses, so the FSM's
  // sampling edge and the visible rising edge coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      tck <= 1'b0;
    end else if (tck_rise_en) begin
      tck <= 1'b1;
    end else if (tck_fall_en || !run) begin
      tck <= 1'b0;
    end
  end

endmodule

// File: rtl/multicore_cpu_1_cpu_debug_host_shifter.sv
// Host-side virtual-JTAG initiator for the Nios II debug slave.
// Takes one command (IR + data word), walks the virtual TAP through
// UIR, CDR, SDR x SR_WIDTH, UDR, RTI, shifting the data word out LSB first
// on vji_tdi while capturing vji_tdo, then presents the captured word.
// Ports:
//   clk, reset            : system clock, synchronous active-high reset
//   bus (slave)           : command in / response out handshake bus
//   busy                  : high in every state other than IDLE
//   vji_tck, vji_tdi      : generated tck and serial data to the slave
//   vji_tdo               : serial data from the slave
//   vji_ir_in, vji_ir_out : virtual IR to the slave / IR status from it
//   vji_uir..vji_rti      : one-hot virtual TAP state strobes
module multicore_cpu_1_cpu_debug_host_shifter
  import multicore_debug_pkg::*;
#(
  parameter int SR_WIDTH = DBG_SR_WIDTH,
  parameter int IR_WIDTH = DBG_IR_WIDTH,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  multicore_cpu_1_cpu_debug_host_shifter_if.slave bus,
  output logic                busy,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int BC_W = $clog2(SR_WIDTH + 1);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(SR_WIDTH - 1);

  dbg_state_t          state;
  logic [4:0]          strobes;
  logic [SR_WIDTH-1:0] sr;
  logic [IR_WIDTH-1:0] ir_in_q;
  logic [IR_WIDTH-1:0] ir_out_q;
  logic [BC_W-1:0]     bit_cnt;
  logic                tdi_q;
  logic                cmd_ready_q;
  logic                rsp_valid_q;
  logic                busy_q;
  logic                run;
  logic                tck_rise_en;
  logic                tck_fall_en;

  assign run = (state != IDLE) && (state != RESP);

  multicore_cpu_1_cpu_debug_host_tckgen #(
    .TCK_DIV (TCK_DIV)
  ) u_tckgen (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .tck         (vji_tck),
    .tck_rise_en (tck_rise_en),
    .tck_fall_en (tck_fall_en)
  );

  // Single FSM block. State changes, strobes and vji_tdi only move on
  // tck_fall_en edges (start of a tck-low phase); TDO and IR status are
  // sampled on tck_rise_en edges. The shift register doubles as the
  // response word, so it is only reloaded on command acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      strobes     <= '0;
      sr          <= '0;
      ir_in_q     <= '0;
      ir_out_q    <= '0;
      bit_cnt     <= '0;
      tdi_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            state       <= UIR;
            strobes     <= state_strobes(UIR);
            sr          <= bus.cmd_data;
            ir_in_q     <= bus.cmd_ir;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        UIR: begin
          if (tck_rise_en) begin
            ir_out_q <= vji_ir_out;
          end
          if (tck_fall_en) begin
            state   <= CDR;
            strobes <= state_strobes(CDR);
          end
        end
        CDR: begin
          if (tck_fall_en) begin
            state   <= SDR;
            strobes <= state_strobes(SDR);
            tdi_q   <= sr[0];
          end
        end
        SDR: begin
          // The shift at the rise edge has already brought the next bit to
          // sr[0] by the time the period ends and tdi is updated.
          if (tck_rise_en) begin
            sr <= {vji_tdo, sr[SR_WIDTH-1:1]};
          end
          if (tck_fall_en) begin
            if (bit_cnt == LAST_BIT) begin
              state   <= UDR;
              strobes <= state_strobes(UDR);
              tdi_q   <= 1'b0;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + BC_W'(1);
              tdi_q   <= sr[0];
            end
          end
        end
        UDR: begin
          if (tck_fall_en) begin
            state   <= RTI;
            strobes <= state_strobes(RTI);
          end
        end
        RTI: begin
          if (tck_fall_en) begin
            state       <= RESP;
            strobes     <= state_strobes(RESP);
            rsp_valid_q <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = sr;
  assign bus.rsp_ir_out = ir_out_q;
  assign busy           = busy_q;
  assign vji_tdi        = tdi_q;
  assign vji_ir_in      = ir_in_q;
  assign {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} = strobes;

endmodule
